iob_wb_arbiter: RTL and testbench
=================================

# iob_wb_arbiter

Round-robin arbiter that shares one IOb slave port between N Wishbone masters, such as the MAC's TX and RX buffer-descriptor/DMA masters. It accepts Wishbone classic cycles, registers the winning request, and issues a single-cycle IOb `valid_o` pulse. It then waits for `ready_i` and returns the acknowledge and read data to the granted master only.

## Interface
- `N_MASTERS`, default 2: number of Wishbone masters, range 2..8.
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width; strobe width is DATA_W/8.
- `TIMEOUT_CYCLES`, default 255: watchdog limit. Only used with `IOB_WB_ARB_TIMEOUT_EN`.
- `clk_i`  in  1  clock; all logic is on the rising edge.
- `rstn_i`  in  1  reset; synchronous, active-low.
- `wb_adr_i`  in  N_MASTERS*ADDR_W  packed addresses; master m occupies slice m.
- `wb_dat_i`  in  N_MASTERS*DATA_W  packed write data.
- `wb_sel_i`  in  N_MASTERS*DATA_W/8  packed byte selects.
- `wb_we_i`, `wb_cyc_i`, `wb_stb_i`  in  N_MASTERS  one bit per master.
- `wb_dat_o`  out  DATA_W  read data, shared by all masters; valid only with that master's ack.
- `wb_ack_o`, `wb_err_o`  out  N_MASTERS  one-hot completion pulses.
- `valid_o`  out  1  IOb request pulse.
- `address_o`  out  ADDR_W  IOb address.
- `wdata_o`  out  DATA_W  IOb write data.
- `wstrb_o`  out  DATA_W/8  IOb write strobes; all zero means a read.
- `rdata_i`  in  DATA_W  IOb read data; valid with `ready_i`.
- `ready_i`  in  1  IOb completion.
- `grant_o`  out  N_MASTERS  one-hot current owner; all zero when IDLE.

## Operation
- A master requests when `wb_cyc_i[m] & wb_stb_i[m]`.
- FSM states: IDLE, REQ, WAIT, RESP.
- **IDLE**
  - If any master requests, pick the winner by round-robin.
  - Register the winner's address, write data, and strobe into holding registers. Strobe is `wb_sel` when `we=1`, else 0.
  - Set `grant_o`, update `last_grant`, go to REQ.
- **Round-robin rule:** search starts at `last_grant+1` (mod N_MASTERS), wraps, and takes the first requester. Reset value of `last_grant` is N_MASTERS-1, so master 0 wins first.
- **REQ**
  - `valid_o=1` for exactly this cycle; the IOb outputs drive the holding registers.
  - If `ready_i=1` in this same cycle, capture `rdata_i` and go to RESP; otherwise go to WAIT.
- **WAIT**
  - `valid_o=0`; IOb address, data and strobe outputs stay stable.
  - On `ready_i`, capture `rdata_i` into the rdata register and go to RESP.
- **RESP**
  - Pulse `wb_ack_o[grant]=1` for one cycle; `wb_dat_o` is the registered rdata.
  - Clear `grant_o` and go to IDLE.
- **Master abandons the cycle:** if the granted master drops `wb_cyc_i` during REQ or WAIT, the IOb transaction still completes. The ack is suppressed in RESP; no error is raised.
- **`ready_i` outside REQ/WAIT:** ignored; does not affect state or rdata.
- **Simultaneous requests:** exactly one master is granted per transaction; the others hold their cycles and are served in round-robin order.
- **Reset values** (`rstn_i=0` at a rising edge, including mid-transaction):
  - State returns to IDLE.
  - `valid_o`, `wb_ack_o`, `wb_err_o` and `grant_o` are 0.
  - `address_o`, `wdata_o`, `wstrb_o` and `wb_dat_o` are 0.
  - `last_grant` is N_MASTERS-1.
  - No IOb transaction is in flight afterwards.

## Timing
- Request sampled in IDLE at cycle t:
  - `valid_o` is asserted at t+1.
  - `ready_i` at cycle k (k ≥ t+1) gives ack at k+1.
  - Minimum transaction is 3 cycles; the fastest case is `ready_i` in the REQ cycle, giving ack at t+2.
- Back-to-back:
  - A classic master removes `stb` by the edge after ack.
  - Any request present in the IDLE cycle after RESP is treated as new.
  - Peak throughput is one transaction per 3 cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `IOB_WB_ARB_TIMEOUT_EN` **defined:**
  - A counter clears on entry to REQ and increments each cycle in REQ/WAIT.
  - If it reaches TIMEOUT_CYCLES without `ready_i`, the FSM goes to RESP with `wb_err_o[grant]=1` instead of ack, and `wb_dat_o` is 0.
  - A `ready_i` in the same cycle the limit is reached wins; the result is a normal ack.
  - A late `ready_i` arriving afterwards is ignored.
- `IOB_WB_ARB_TIMEOUT_EN` **undefined:**
  - No counter is built.
  - `wb_err_o` is tied to 0.
  - WAIT lasts until `ready_i`.

## Structure
- **Shared package `iob_wb_arbiter_pkg`:**
  - FSM state encoding (IDLE=2'd0, REQ=2'd1, WAIT=2'd2, RESP=2'd3).
  - Maximum N_MASTERS constant.
  - Function computing the index width from N_MASTERS.
- **Sub-module `iob_rr_arbiter`:**
  - Combinational round-robin pick from a request vector and `last_grant`.
  - Outputs a one-hot grant plus a valid flag.
  - Instantiated once.

## Test plan
- **Single read:** master 0 reads 0x100; slave returns `ready_i` 2 cycles after `valid_o` with rdata 0xDEADBEEF. Expect:
  - `valid_o` high exactly 1 cycle, with `address_o`=0x100 and `wstrb_o`=0.
  - `wb_ack_o`=2'b01 for 1 cycle with `wb_dat_o`=0xDEADBEEF.
- **Write:** master 1 writes 0x12345678, sel 4'b0011. Expect `wstrb_o`=4'b0011 and `wdata_o`=0x12345678 held from REQ until `ready_i`, then `wb_ack_o`=2'b10.
- **Contention:** both masters request continuously for 6 transactions. Expect grants in order 0,1,0,1,0,1 with no starvation and one ack per grant.
- **Zero-wait slave:** `ready_i` asserted in the REQ cycle. Expect ack 2 cycles after the request was sampled, and `ready_i` in IDLE ignored.
- **Reset mid-WAIT:** `rstn_i` low for 1 cycle while WAITing. Expect:
  - All outputs 0 and state IDLE.
  - A subsequent `ready_i` is ignored.
  - The next requester is master 0.
- **Timeout** (`IOB_WB_ARB_TIMEOUT_EN` defined, TIMEOUT_CYCLES=8): slave never readies. Expect `wb_err_o`=2'b01 after 8 REQ/WAIT cycles, no ack, and a late `ready_i` ignored.

Source files
------------

// File: rtl/iob_wb_arbiter_pkg.sv
// Shared definitions for the Wishbone-to-IOb round-robin arbiter:
// FSM state encoding, the supported master count and an index-width helper.
package iob_wb_arbiter_pkg;

  localparam int MAX_MASTERS = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  // Bits needed to hold a master index; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/iob_wb_arbiter_if.sv
// Bus bundle between N Wishbone masters, the arbiter and one IOb slave.
// Signal suffixes are from the arbiter's point of view. The arbiter is the
// Wishbone slave, so it uses the "slave" modport. The surrounding system
// (the masters plus the IOb slave) uses the "master" modport.
interface iob_wb_arbiter_if #(
  parameter int N_MASTERS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
);
  logic [N_MASTERS*ADDR_W-1:0]     wb_adr_i;
  logic [N_MASTERS*DATA_W-1:0]     wb_dat_i;
  logic [N_MASTERS*(DATA_W/8)-1:0] wb_sel_i;
  logic [N_MASTERS-1:0]            wb_we_i;
  logic [N_MASTERS-1:0]            wb_cyc_i;
  logic [N_MASTERS-1:0]            wb_stb_i;
  logic [DATA_W-1:0]               wb_dat_o;
  logic [N_MASTERS-1:0]            wb_ack_o;
  logic [N_MASTERS-1:0]            wb_err_o;
  logic                            valid_o;
  logic [ADDR_W-1:0]               address_o;
  logic [DATA_W-1:0]               wdata_o;
  logic [DATA_W/8-1:0]             wstrb_o;
  logic [DATA_W-1:0]               rdata_i;
  logic                            ready_i;
  logic [N_MASTERS-1:0]            grant_o;

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
    input  rdata_i, ready_i,
    output wb_dat_o, wb_ack_o, wb_err_o,
    output valid_o, address_o, wdata_o, wstrb_o, grant_o
  );

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
    output rdata_i, ready_i,
    input  wb_dat_o, wb_ack_o, wb_err_o,
    input  valid_o, address_o, wdata_o, wstrb_o, grant_o
  );
endinterface

// File: rtl/iob_rr_arbiter.sv
// Combinational round-robin pick. The search starts one past last_i and
// wraps, and the first active request wins. A one-hot grant is returned.
module iob_rr_arbiter #(
  parameter int N_MASTERS = 2,
  parameter int IDX_W     = 1
) (
  input  logic [N_MASTERS-1:0] req_i,
  input  logic [IDX_W-1:0]     last_i,
  output logic [N_MASTERS-1:0] grant_o,
  output logic                 valid_o
);

  // Walk the masters in rotated order and keep the first requester.
  always_comb begin
    int idx;
    logic [IDX_W-1:0] sel;
    grant_o = '0;
    valid_o = 1'b0;
    idx     = 0;
    sel     = '0;
    for (int i = 1; i <= N_MASTERS; i++) begin
      idx = int'(last_i) + i;
      if (idx >= N_MASTERS) idx = idx - N_MASTERS;
      sel = IDX_W'(idx);
      if (!valid_o && req_i[sel]) begin
        grant_o[sel] = 1'b1;
        valid_o      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/iob_wb_arbiter.sv
// Round-robin arbiter that shares one IOb slave between N Wishbone masters.
// Every output is registered.
// Optional watchdog: define IOB_WB_ARB_TIMEOUT_EN to end a stalled IOb
// transaction with wb_err_o after TIMEOUT_CYCLES cycles in REQ/WAIT.
//
// state   | meaning
// IDLE    | no transaction; arbitrate and latch the winner's request
// REQ     | valid_o pulse to the IOb slave; ready_i may arrive here
// WAIT    | request held stable until ready_i (or the watchdog fires)
// RESP    | ack/err pulse to the granted master; grant released
module iob_wb_arbiter
  import iob_wb_arbiter_pkg::*;
#(
  parameter int N_MASTERS      = 2,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  iob_wb_arbiter_if.slave bus_if
);

  localparam int IW = idx_width(N_MASTERS);
  localparam int SW = DATA_W / 8;

  if (N_MASTERS < 2 || N_MASTERS > MAX_MASTERS) begin : g_bad_n
    $error("iob_wb_arbiter: N_MASTERS out of range");
  end

  state_e               state_q, state_d;
  logic [N_MASTERS-1:0] grant_q, grant_d, ack_q, ack_d;
  logic [N_MASTERS-1:0] req, rr_grant;
  logic                 rr_valid;
  logic [IW-1:0]        last_q, last_d, win_idx;
  logic [ADDR_W-1:0]    adr_q, adr_d, win_adr;
  logic [DATA_W-1:0]    wdat_q, wdat_d, win_dat, rdata_q, rdata_d;
  logic [SW-1:0]        strb_q, strb_d, win_strb;
  logic                 valid_q, valid_d, aband_q, aband_d;
  logic                 dropped, tmo_hit;

  assign req     = bus_if.wb_cyc_i & bus_if.wb_stb_i;
  assign dropped = ~|(grant_q & bus_if.wb_cyc_i);

  iob_rr_arbiter #(.N_MASTERS(N_MASTERS), .IDX_W(IW)) u_rr (
    .req_i   (req),
    .last_i  (last_q),
    .grant_o (rr_grant),
    .valid_o (rr_valid)
  );

  // Select the winner's index and request fields using the one-hot grant.
  always_comb begin
    win_idx  = '0;
    win_adr  = '0;
    win_dat  = '0;
    win_strb = '0;
    for (int m = 0; m < N_MASTERS; m++) begin
      if (rr_grant[m]) begin
        win_idx  = IW'(m);
        win_adr  = bus_if.wb_adr_i[m*ADDR_W +: ADDR_W];
        win_dat  = bus_if.wb_dat_i[m*DATA_W +: DATA_W];
        win_strb = bus_if.wb_we_i[m] ? bus_if.wb_sel_i[m*SW +: SW] : '0;
      end
    end
  end

`ifdef IOB_WB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [N_MASTERS-1:0] err_q, err_d;

  assign tmo_hit = (state_q == ST_REQ || state_q == ST_WAIT) &&
                   (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  // Watchdog: clear when REQ is entered, count every REQ/WAIT cycle, and flag the granted master when it expires.
  always_comb begin
    cnt_d = cnt_q;
    err_d = '0;
    if (state_q == ST_IDLE && rr_valid) begin
      cnt_d = '0;
    end else if (state_q == ST_REQ || state_q == ST_WAIT) begin
      cnt_d = cnt_q + 1'b1;
      if (tmo_hit && !bus_if.ready_i && !(aband_q || dropped)) err_d = grant_q;
    end
  end

  // Watchdog registers.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      cnt_q <= '0;
      err_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign bus_if.wb_err_o = err_q;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign tmo_hit         = 1'b0;
  assign bus_if.wb_err_o = '0;
`endif

  // Next-state logic and datapath updates for the request/response FSM.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    adr_d   = adr_q;
    wdat_d  = wdat_q;
    strb_d  = strb_q;
    rdata_d = rdata_q;
    aband_d = aband_q;
    valid_d = 1'b0;
    ack_d   = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (rr_valid) begin
          state_d = ST_REQ;
          grant_d = rr_grant;
          last_d  = win_idx;
          adr_d   = win_adr;
          wdat_d  = win_dat;
          strb_d  = win_strb;
          aband_d = 1'b0;
          valid_d = 1'b1;
        end
      end
      ST_REQ, ST_WAIT: begin
        // The IOb side always completes. A master that left its cycle only loses the ack.
        aband_d = aband_q | dropped;
        if (bus_if.ready_i) begin
          state_d = ST_RESP;
          rdata_d = bus_if.rdata_i;
          if (!(aband_q || dropped)) ack_d = grant_q;
        end else if (tmo_hit) begin
          state_d = ST_RESP;
          rdata_d = '0;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and holding registers.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= IW'(N_MASTERS - 1);
      adr_q   <= '0;
      wdat_q  <= '0;
      strb_q  <= '0;
      rdata_q <= '0;
      aband_q <= 1'b0;
      valid_q <= 1'b0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      adr_q   <= adr_d;
      wdat_q  <= wdat_d;
      strb_q  <= strb_d;
      rdata_q <= rdata_d;
      aband_q <= aband_d;
      valid_q <= valid_d;
      ack_q   <= ack_d;
    end
  end

  assign bus_if.valid_o   = valid_q;
  assign bus_if.address_o = adr_q;
  assign bus_if.wdata_o   = wdat_q;
  assign bus_if.wstrb_o   = strb_q;
  assign bus_if.wb_dat_o  = rdata_q;
  assign bus_if.wb_ack_o  = ack_q;
  assign bus_if.grant_o   = grant_q;

endmodule

// File: tb/tb_iob_wb_arbiter.sv
// Directed bench for iob_wb_arbiter (two masters, 32-bit bus). The
// watchdog scenario is included when IOB_WB_ARB_TIMEOUT_EN is defined,
// with TIMEOUT_CYCLES set to 8.
module tb_iob_wb_arbiter;

  logic clk_i  = 1'b0;
  logic rstn_i = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  iob_wb_arbiter_if #(.N_MASTERS(2), .ADDR_W(32), .DATA_W(32)) bus_if ();

  iob_wb_arbiter #(
    .N_MASTERS(2), .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .bus_if (bus_if)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock edge, then settle just past it.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drop_all();
    bus_if.wb_cyc_i = '0;
    bus_if.wb_stb_i = '0;
    bus_if.wb_we_i  = '0;
  endtask

  // One transaction from master m, which is expected to win arbitration.
  // wait_n is the number of WAIT cycles before ready_i (0 means ready_i in REQ).
  task automatic xfer(input int m, input logic we, input logic [31:0] adr,
                      input logic [31:0] wd, input logic [3:0] sel,
                      input int wait_n, input logic [31:0] rd);
    logic [3:0] exp_strb;
    exp_strb = we ? sel : 4'h0;
    drop_all();
    bus_if.wb_cyc_i[m] = 1'b1;
    bus_if.wb_stb_i[m] = 1'b1;
    bus_if.wb_we_i[m]  = we;
    bus_if.wb_adr_i[m*32 +: 32] = adr;
    bus_if.wb_dat_i[m*32 +: 32] = wd;
    bus_if.wb_sel_i[m*4 +: 4]   = sel;
    tick();
    check("req_valid", bus_if.valid_o, 1);
    check("req_grant", bus_if.grant_o, 64'(1) << m);
    check("req_addr", bus_if.address_o, adr);
    check("req_wdata", bus_if.wdata_o, wd);
    check("req_wstrb", bus_if.wstrb_o, exp_strb);
    if (wait_n == 0) begin
      bus_if.ready_i = 1'b1;
      bus_if.rdata_i = rd;
    end
    for (int i = 1; i <= wait_n; i++) begin
      tick();
      check("wait_valid", bus_if.valid_o, 0);
      check("wait_addr", bus_if.address_o, adr);
      check("wait_wdata", bus_if.wdata_o, wd);
      check("wait_wstrb", bus_if.wstrb_o, exp_strb);
      check("wait_ack", bus_if.wb_ack_o, 0);
      if (i == wait_n) begin
        bus_if.ready_i = 1'b1;
        bus_if.rdata_i = rd;
      end
    end
    tick();
    bus_if.ready_i = 1'b0;
    bus_if.rdata_i = '0;
    drop_all();
    check("resp_ack", bus_if.wb_ack_o, 64'(1) << m);
    check("resp_dat", bus_if.wb_dat_o, rd);
    check("resp_err", bus_if.wb_err_o, 0);
    check("resp_valid", bus_if.valid_o, 0);
    tick();
    check("idle_ack", bus_if.wb_ack_o, 0);
    check("idle_grant", bus_if.grant_o, 0);
  endtask

  initial begin
    int exp_m;
    bus_if.wb_adr_i = '0;
    bus_if.wb_dat_i = '0;
    bus_if.wb_sel_i = '0;
    drop_all();
    bus_if.ready_i = 1'b0;
    bus_if.rdata_i = '0;

    // Reset values
    repeat (2) tick();
    check("rst_valid", bus_if.valid_o, 0);
    check("rst_ack", bus_if.wb_ack_o, 0);
    check("rst_err", bus_if.wb_err_o, 0);
    check("rst_grant", bus_if.grant_o, 0);
    check("rst_addr", bus_if.address_o, 0);
    check("rst_wdata", bus_if.wdata_o, 0);
    check("rst_wstrb", bus_if.wstrb_o, 0);
    check("rst_dat", bus_if.wb_dat_o, 0);
    rstn_i = 1'b1;
    tick();

    // Single read: master 0, ready two cycles after valid
    xfer(0, 1'b0, 32'h0000_0100, 32'h0, 4'hF, 2, 32'hDEAD_BEEF);

    // Write: master 1, strobe held through three WAIT cycles
    xfer(1, 1'b1, 32'h0000_0040, 32'h1234_5678, 4'b0011, 3, 32'h0000_0000);

    // ready_i in IDLE is ignored
    bus_if.ready_i = 1'b1;
    bus_if.rdata_i = 32'hBAD0_BAD0;
    tick();
    bus_if.ready_i = 1'b0;
    bus_if.rdata_i = '0;
    check("idle_rdy_valid", bus_if.valid_o, 0);
    check("idle_rdy_ack", bus_if.wb_ack_o, 0);
    check("idle_rdy_grant", bus_if.grant_o, 0);
    check("idle_rdy_dat", bus_if.wb_dat_o, 0);

    // Zero-wait slave: ack two cycles after the request is sampled
    xfer(0, 1'b0, 32'h0000_0180, 32'h0, 4'hF, 0, 32'hCAFE_0001);

    // Master 1 abandons its cycle; the IOb side completes and the ack is suppressed
    bus_if.wb_cyc_i[1] = 1'b1;
    bus_if.wb_stb_i[1] = 1'b1;
    bus_if.wb_adr_i[63:32] = 32'h0000_0500;
    tick();
    check("abn_grant", bus_if.grant_o, 2'b10);
    drop_all();
    tick();
    bus_if.ready_i = 1'b1;
    bus_if.rdata_i = 32'h0000_0077;
    tick();
    bus_if.ready_i = 1'b0;
    bus_if.rdata_i = '0;
    check("abn_ack", bus_if.wb_ack_o, 0);
    check("abn_err", bus_if.wb_err_o, 0);
    check("abn_dat", bus_if.wb_dat_o, 32'h0000_0077);
    tick();
    check("abn_idle_grant", bus_if.grant_o, 0);

    // Reset during WAIT: master 0 is granted (last grant was 1)
    bus_if.wb_cyc_i[0] = 1'b1;
    bus_if.wb_stb_i[0] = 1'b1;
    bus_if.wb_adr_i[31:0] = 32'h0000_0400;
    tick();
    check("rw_grant", bus_if.grant_o, 2'b01);
    tick();
    rstn_i = 1'b0;
    drop_all();
    tick();
    rstn_i = 1'b1;
    check("rw_valid", bus_if.valid_o, 0);
    check("rw_grant0", bus_if.grant_o, 0);
    check("rw_addr", bus_if.address_o, 0);
    check("rw_dat", bus_if.wb_dat_o, 0);
    bus_if.ready_i = 1'b1;
    bus_if.rdata_i = 32'h0000_0055;
    tick();
    bus_if.ready_i = 1'b0;
    bus_if.rdata_i = '0;
    check("rw_late_ack", bus_if.wb_ack_o, 0);
    check("rw_late_dat", bus_if.wb_dat_o, 0);
    check("rw_late_valid", bus_if.valid_o, 0);

    // Contention: both masters request continuously; reset restored last grant so master 0 goes first
    bus_if.wb_cyc_i = 2'b11;
    bus_if.wb_stb_i = 2'b11;
    bus_if.wb_we_i  = 2'b00;
    bus_if.wb_adr_i = {32'h0000_0300, 32'h0000_0200};
    for (int i = 0; i < 6; i++) begin
      exp_m = i % 2;
      tick();
      check("ct_valid", bus_if.valid_o, 1);
      check("ct_grant", bus_if.grant_o, 64'(1) << exp_m);
      check("ct_addr", bus_if.address_o, (exp_m == 1) ? 32'h0000_0300 : 32'h0000_0200);
      bus_if.ready_i = 1'b1;
      bus_if.rdata_i = 32'hA0 + 32'(i);
      tick();
      bus_if.ready_i = 1'b0;
      bus_if.rdata_i = '0;
      check("ct_ack", bus_if.wb_ack_o, 64'(1) << exp_m);
      check("ct_dat", bus_if.wb_dat_o, 32'hA0 + 32'(i));
      tick();
      check("ct_idle_ack", bus_if.wb_ack_o, 0);
    end
    drop_all();
    tick();

`ifdef IOB_WB_ARB_TIMEOUT_EN
    // Watchdog: slave never readies; error after 8 REQ/WAIT cycles
    bus_if.wb_cyc_i[0] = 1'b1;
    bus_if.wb_stb_i[0] = 1'b1;
    bus_if.wb_adr_i[31:0] = 32'h0000_0600;
    tick();
    check("to_grant", bus_if.grant_o, 2'b01);
    for (int i = 0; i < 7; i++) begin
      tick();
      check("to_wait_err", bus_if.wb_err_o, 0);
    end
    tick();
    check("to_err", bus_if.wb_err_o, 2'b01);
    check("to_ack", bus_if.wb_ack_o, 0);
    check("to_dat", bus_if.wb_dat_o, 0);
    drop_all();
    tick();
    bus_if.ready_i = 1'b1;
    bus_if.rdata_i = 32'h0000_0099;
    tick();
    bus_if.ready_i = 1'b0;
    check("to_late_ack", bus_if.wb_ack_o, 0);
    check("to_late_err", bus_if.wb_err_o, 0);
    check("to_late_dat", bus_if.wb_dat_o, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
